// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: control-bit positions, write-back
// select encodings and the memory-stage state type.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 5;

  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_REGWRITE = 2;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: combinational read port, synchronous write port.
module data_mem
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: clears data memory after reset, then performs word
// loads/stores and registers results into the MEM/WB register.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrl_mem,
  input  logic [XLEN-1:0]   rd_mem,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   write_data1,
  input  logic [XLEN-1:0]   pc4_mem,
  output logic [2:0]        ctrl_wb,
  output logic [XLEN-1:0]   rd_wb,
  output logic [XLEN-1:0]   alu_result_wb,
  output logic [XLEN-1:0]   read_data,
  output logic [XLEN-1:0]   pc4_wb,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  mem_state_e       r_state;
  mem_state_e       w_next_state;
  logic [IDX_W-1:0] r_clr_cnt;

  logic [2:0]       r_ctrl;
  logic [XLEN-1:0]  r_rd;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  r_pc4;
  logic             r_busy;
  logic             r_err;

  logic [2:0]       w_ctrl_d;
  logic [XLEN-1:0]  w_rd_d;
  logic [XLEN-1:0]  w_alu_d;
  logic [XLEN-1:0]  w_rdata_d;
  logic [XLEN-1:0]  w_pc4_d;
  logic             w_err_d;

  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_mem_rdata;

  // Address decode and legality of the requested access
  logic [IDX_W-1:0] w_idx;
  logic             w_mem_rd;
  logic             w_mem_wr;
  logic             w_aligned;
  logic             w_in_range;
  logic             w_legal;
  logic             w_store;
  logic             w_load;
  logic             w_illegal;

  assign w_idx      = alu_result[IDX_W+1:2];
  assign w_mem_rd   = ctrl_mem[CTRL_MEMREAD];
  assign w_mem_wr   = ctrl_mem[CTRL_MEMWRITE];
  assign w_aligned  = (alu_result[1:0] == 2'b00);
  assign w_in_range = (alu_result[XLEN-1:IDX_W+2] == '0);
  assign w_legal    = w_aligned & w_in_range & ~(w_mem_rd & w_mem_wr);
  assign w_store    = w_mem_wr & w_legal;
  assign w_load     = w_mem_rd & w_legal;
  assign w_illegal  = (w_mem_rd | w_mem_wr) & ~w_legal;

  data_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  // Next state, memory write-port mux and next MEM/WB register contents
  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_waddr      = r_clr_cnt;
    w_wdata      = '0;
    w_ctrl_d     = '0;
    w_rd_d       = '0;
    w_alu_d      = '0;
    w_rdata_d    = '0;
    w_pc4_d      = '0;
    w_err_d      = r_err;
    unique case (r_state)
      INIT: begin
        w_we = 1'b1;
        if (r_clr_cnt == IDX_W'(MEM_DEPTH - 1)) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_we     = w_store;
        w_waddr  = w_idx;
        w_wdata  = write_data1;
        w_ctrl_d = ctrl_mem[2:0];
        w_rd_d   = rd_mem;
        w_alu_d  = alu_result;
        w_pc4_d  = pc4_mem;
        if (w_load) begin
          w_rdata_d = w_mem_rdata;
        end
        if (w_illegal) begin
          w_err_d = 1'b1;
        end
      end
    endcase
  end

  // State, clear counter and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
      r_ctrl    <= '0;
      r_rd      <= '0;
      r_alu     <= '0;
      r_rdata   <= '0;
      r_pc4     <= '0;
      r_busy    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == INIT) begin
        r_clr_cnt <= r_clr_cnt + IDX_W'(1);
      end
      r_ctrl  <= w_ctrl_d;
      r_rd    <= w_rd_d;
      r_alu   <= w_alu_d;
      r_rdata <= w_rdata_d;
      r_pc4   <= w_pc4_d;
      r_busy  <= (w_next_state == INIT);
      r_err   <= w_err_d;
    end
  end

  assign ctrl_wb       = r_ctrl;
  assign rd_wb         = r_rd;
  assign alu_result_wb = r_alu;
  assign read_data     = r_rdata;
  assign pc4_wb        = r_pc4;
  assign mem_busy      = r_busy;
  assign mem_err       = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes one expected MEM/WB result
// per cycle from a reference model; the monitor pops and compares.
module tb_mem_stage;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ctrl_mem;
  logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
  logic [2:0]  ctrl_wb;
  logic [31:0] rd_wb, alu_result_wb, read_data, pc4_wb;
  logic        mem_busy, mem_err;

  mem_stage #(.MEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_mem      (ctrl_mem),
    .rd_mem        (rd_mem),
    .alu_result    (alu_result),
    .write_data1   (write_data1),
    .pc4_mem       (pc4_mem),
    .ctrl_wb       (ctrl_wb),
    .rd_wb         (rd_wb),
    .alu_result_wb (alu_result_wb),
    .read_data     (read_data),
    .pc4_wb        (pc4_wb),
    .mem_busy      (mem_busy),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [2:0]  ctrl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic        m_err = 1'b0;
  int          init_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: compare the DUT's MEM/WB outputs against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_result: expected due cyc %0d, now %0d", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ctrl_wb",       32'(ctrl_wb),  32'(e.ctrl));
      chk("rd_wb",         rd_wb,         e.rd);
      chk("alu_result_wb", alu_result_wb, e.alu);
      chk("read_data",     read_data,     e.rdata);
      chk("pc4_wb",        pc4_wb,        e.pc4);
      chk("mem_busy",      32'(mem_busy), 32'(e.busy));
      chk("mem_err",       32'(mem_err),  32'(e.err));
    end
  end

  // Drive one cycle of inputs and push the response the next edge must produce
  task automatic step(input logic [4:0] c, input logic [31:0] rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] p4);
    exp_t e;
    logic mr, mw, ok;
    ctrl_mem = c; rd_mem = rd; alu_result = a; write_data1 = wd; pc4_mem = p4;
    e = '{due: cyc + 1, ctrl: 3'b0, rd: 0, alu: 0, rdata: 0, pc4: 0, busy: 1'b1, err: 1'b0};
    if (reset) begin
      init_left = DEPTH;
      m_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else if (init_left > 0) begin
      init_left--;
      e.busy = (init_left > 0);
      e.err  = m_err;
    end else begin
      mr = c[3];
      mw = c[4];
      ok = (a % 4 == 0) && (a < 4 * DEPTH) && !(mr && mw);
      if (mr && !mw && ok) e.rdata = m_mem[a / 4];
      if (mw && !mr && ok) m_mem[a / 4] = wd;
      if ((mr || mw) && !ok) m_err = 1'b1;
      e.ctrl = c[2:0]; e.rd = rd; e.alu = a; e.pc4 = p4;
      e.busy = 1'b0; e.err = m_err;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic garbage_step();
    step(5'($urandom), $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) garbage_step();
    reset = 1'b0;
  endtask

  task automatic init_cycles(input int n);
    for (int i = 0; i < n; i++) garbage_step();
  endtask

  task automatic ld(input logic [31:0] a);
    step(5'b01101, $urandom_range(0, 31), a, $urandom, $urandom);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    step(5'b10000, $urandom_range(0, 31), a, d, $urandom);
  endtask

  initial begin
    logic [4:0]  c;
    logic [31:0] a;
    int          sel;
    reset = 1'b1;
    ctrl_mem = '0; rd_mem = '0; alu_result = '0; write_data1 = '0; pc4_mem = '0;

    // Reset, full clear, load of the top word
    reset_cycles(2);
    init_cycles(DEPTH);
    ld(32'h0000_003C);

    // Store then load back-to-back
    st(32'h0000_0008, 32'hDEAD_BEEF);
    ld(32'h0000_0008);

    // Misaligned load, out-of-range store, then read back every word
    ld(32'h0000_000A);
    st(32'h0000_0040, 32'hA5A5_A5A5);
    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4));

    // Read and write together
    step(5'b11000, 32'h3, 32'h0000_0004, 32'h1234_5678, 32'h8);
    ld(32'h0000_0004);

    // Pass-through with reserved-free wb_sel 10
    step(5'b00110, 32'h0000_001F, 32'h7FFF_FFFF, 32'h0, 32'h0000_0104);
    step(5'b00011, 32'h1, 32'h4, 32'h0, 32'h8);

    // Reset during INIT restarts the whole clear
    st(32'h0000_0000, 32'hCAFE_F00D);
    ld(32'h0000_0000);
    reset_cycles(1);
    init_cycles(5);
    reset_cycles(1);
    init_cycles(DEPTH);
    ld(32'h0000_0000);

    // Random legal-only traffic: mem_err must stay low
    for (int i = 0; i < 200; i++) begin
      c = 5'($urandom);
      if (c[4] && c[3]) c[4] = 1'b0;
      a = (c[4] || c[3]) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
      step(c, $urandom, a, $urandom, $urandom);
    end

    // Fully random traffic including illegal accesses
    for (int i = 0; i < 300; i++) begin
      c   = 5'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 32'($urandom_range(0, DEPTH - 1) * 4);
        1:       a = 32'($urandom_range(0, 4 * DEPTH - 1));
        2:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      step(c, $urandom, a, $urandom, $urandom);
    end
    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4));

    step(5'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 32-bit RISC-V five-stage pipeline, consuming the EX-stage outputs (ctrl_mem, rd_mem, alu_result, write_data1, pc4_mem). Performs word loads/stores against an internal data memory and registers results into the MEM/WB pipeline register toward write-back. After reset, a hardware clear sequence zeroes the memory while holding the pipeline via `mem_busy`.

## Interface
- MEM_DEPTH, 256, data memory size in 32-bit words; power of two, minimum 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_mem  in  5  [4] mem_write, [3] mem_read, [2] reg_write, [1:0] wb_sel (00 ALU, 01 load data, 10 PC+4, 11 reserved).
- rd_mem  in  32  destination register field, passed through.
- alu_result  in  32  byte address for load/store; otherwise the ALU value, passed through.
- write_data1  in  32  store data.
- pc4_mem  in  32  PC+4, passed through.
- ctrl_wb  out  3  registered ctrl_mem[2:0].
- rd_wb  out  32  registered rd_mem.
- alu_result_wb  out  32  registered alu_result.
- read_data  out  32  registered load data.
- pc4_wb  out  32  registered pc4_mem.
- mem_busy  out  1  high while the memory clear runs; upstream holds and issues nothing.
- mem_err  out  1  sticky access-error flag.

## Operation
- FSM states: INIT (clearing), RUN.
- Reset: state INIT, clear counter 0, all outputs 0 except mem_busy = 1.
- INIT: on each edge, write 0 to word[counter] and increment. On the edge that writes word MEM_DEPTH-1, go to RUN. Inputs are ignored. WB register loads a bubble (all zeros).
- RUN: on every edge, the WB register loads ctrl_wb = ctrl_mem[2:0] and rd_wb, alu_result_wb, pc4_wb from their inputs.
- Word index = alu_result[log2(MEM_DEPTH)+1:2].
- Access is legal when alu_result[1:0] == 0 and all address bits above the index are 0.
- Store (mem_write=1, mem_read=0, legal): word[index] <= write_data1 at the edge.
- Load (mem_read=1, mem_write=0, legal): read_data <= word[index], using the array value before this edge.
- No memory op: read_data <= 0.
- Illegal access (misaligned or out of range) with mem_read or mem_write set:
  - no memory write;
  - read_data <= 0;
  - mem_err <= 1.
- mem_read and mem_write both set: treated as illegal whatever the address.
- mem_err stays 1 until reset.
- wb_sel = 11 is passed through unchanged; it is not an error here.
- Reset in any state, including mid-INIT: back to INIT, counter 0, full clear restarts.

## Timing
- Latency: 1 cycle from inputs to the WB outputs.
- Store then load to the same address on the next cycle returns the new data; no bypass is needed because the write completes at the edge.
- mem_busy is high during reset and for exactly MEM_DEPTH cycles after reset deasserts. It is low starting with the cycle after the final clear edge.
- The first RUN edge captures inputs presented while mem_busy was low.
- mem_err rises on the edge that samples the offending access.

## Structure
- Shared package riscv_pkg holds:
  - ctrl_mem bit positions (CTRL_MEMWRITE=4, CTRL_MEMREAD=3, CTRL_REGWRITE=2);
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4);
  - the state enum {INIT, RUN}.
- One sub-module, data_mem:
  - MEM_DEPTH × 32 array;
  - combinational read port;
  - synchronous write port.
  - mem_stage muxes the write port between the clear counter (INIT) and the store path (RUN).
- FSM, legality check and MEM/WB register live in mem_stage.

## Test plan
All cases use MEM_DEPTH=16.
- Reset, then release: mem_busy = 1 for exactly 16 cycles, then 0. A load from 0x0000003C during RUN returns 0x00000000.
- Store 0xDEADBEEF to 0x00000008, then load 0x00000008 next cycle: read_data = 0xDEADBEEF one cycle after the load, ctrl_wb = 3'b101.
- Load from 0x0000000A (misaligned): read_data = 0, mem_err = 1 and stays 1. A later store to 0x00000040 (out of range) leaves all 16 words unchanged.
- mem_read and mem_write both set at 0x00000004 with data 0x12345678: word 1 unchanged, read_data = 0, mem_err = 1.
- Pass-through with ctrl_mem = 5'b00110, rd_mem = 0x0000001F, alu_result = 0x7FFFFFFF, pc4_mem = 0x00000104: next cycle ctrl_wb = 3'b110, all pass-through values match, read_data = 0.
- Store 0xCAFEF00D to 0x00000000, then assert reset for one cycle 5 cycles into a restarted INIT: mem_busy = 1 for 16 full cycles after release, and word 0 reads 0.
